dac_spi_serializer: RTL and testbench
=====================================

// Module: dac_spi_serializer
// PURPOSE
//  Downstream stage of image_wave_gen. Samples the 8-bit xdac/ydac codes and
//  shifts them out as two 16-bit SPI frames to a dual-channel external DAC
//  (MCP4802-style): channel A = X, channel B = Y. One LDAC pulse then updates
//  both DAC outputs together. SPI mode 0, MSB first, one update per request.
// PARAMETERS
//  CLK_DIV  2   clk cycles per SCLK half-period (>=1; 0 illegal)
//  DATA_W   8   DAC code width (fixed at 8 in this revision)
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  synchronous reset, active low
//  sample_valid  in   1  update request; sampled only in IDLE
//  xdac          in   8  X code, sent on channel A
//  ydac          in   8  Y code, sent on channel B
//  dac_en        in   1  1 = DAC active (SHDN_N=1), 0 = shutdown bit sent
//  busy          out  1  high whenever state != IDLE
//  frame_done    out  1  one-cycle pulse when an update completes
//  spi_sclk      out  1  SPI clock, idles low
//  spi_mosi      out  1  SPI data, changes only while sclk is low
//  spi_cs_n      out  1  chip select, active low, one assertion per channel
//  ldac_n        out  1  DAC latch strobe, active low
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state IDLE, cs_n=1, sclk=0, mosi=0,
//    ldac_n=1, busy=0, frame_done=0, divider and bit counter cleared.
//  - Reset mid-transfer aborts immediately. No ldac_n pulse and no
//    frame_done for the aborted update.
//  - Accept: in IDLE with sample_valid=1, latch xdac, ydac and dac_en in
//    the same cycle. busy=1 from the next cycle. Inputs are ignored while
//    busy; mid-update changes are never transmitted.
//  - Frame word, bit15..0: {ch, 1'b0, GA_N=1, SHDN_N=dac_en, code[7:0],
//    4'b0000}. ch=0 for X, ch=1 for Y.
//  - Each state step lasts exactly CLK_DIV cycles (divider tick):
//      CS_SETUP_A: cs_n=0, sclk=0, mosi=bit15                   1 step
//      SHIFT_A: 16 bits; per bit sclk=1 for 1 step, then sclk=0
//        for 1 step. mosi moves to the next bit on each falling
//        edge. The last low half is the CS hold.                 32 steps
//      GAP_A: cs_n=1, mosi=0                                     1 step
//      CS_SETUP_B / SHIFT_B / GAP_B: same sequence, channel B    34 steps
//      LDAC: ldac_n=0                                            1 step
//      DONE: frame_done=1, busy=1                                1 cycle
//    Then IDLE, where a new request is accepted. The acceptance edge to
//    the frame_done cycle spans 69*CLK_DIV+1 cycles.
//  - Back-to-back: sample_valid held high gives a new acceptance on the
//    first IDLE cycle after DONE.
//  - Exactly 16 rising sclk edges per cs_n low window. sclk is never high
//    while cs_n=1.
//  - All outputs are registered; there are no combinational paths from
//    inputs to outputs.
// STRUCTURE
//  - Shared package dandy_pkg: state encoding (IDLE, CS_SETUP, SHIFT, GAP,
//    LDAC, DONE), frame bit-position constants (CH_BIT=15, GA_BIT=13,
//    SHDN_BIT=12, DATA_LSB=4), DATA_W.
//  - Sub-module spi_tick_gen: CLK_DIV counter giving a one-cycle tick. Its
//    clear input is driven by rst_n and by acceptance.
//  - Top: FSM, channel flag, 5-bit half-bit counter, 16-bit shift register.
// TESTING
//  1. Hold rst_n=0 for 3 cycles -> cs_n=1, sclk=0, mosi=0, ldac_n=1,
//     busy=0, frame_done=0.
//  2. CLK_DIV=2, xdac=0xFA, ydac=0x0A, dac_en=1, 1-cycle sample_valid ->
//     bench SPI slave captures 0x3FA0 then 0xB0A0; ldac_n low for 2
//     cycles after the second cs_n rise; frame_done 139 cycles after
//     acceptance.
//  3. dac_en=0, xdac=0x55 -> channel A word 0x2550; bit12=0 on both words.
//  4. sample_valid held high, xdac changed every cycle -> each frame
//     carries the value present at its acceptance cycle; updates are
//     back-to-back with one IDLE cycle between frame_done and next busy.
//  5. rst_n pulsed low after the 5th rising sclk of channel A -> cs_n=1
//     the next cycle, no ldac_n pulse, no frame_done; the next request
//     yields complete, correct frames.
//  6. CLK_DIV=1, xdac=0x00, ydac=0xFF -> words 0x3000 and 0xBFF0;
//     frame_done 70 cycles after acceptance.

Source files
------------

// File: rtl/dac_spi_serializer_pkg.sv
// Shared types and frame layout for the dual-channel DAC serializer.
// Frame word (MSB first): {ch, 0, GA_N, SHDN_N, code[7:0], 4'b0000}.
package dandy_pkg;

  localparam int DATA_W   = 8;
  localparam int FRAME_W  = 16;
  localparam int CH_BIT   = 15;
  localparam int GA_BIT   = 13;
  localparam int SHDN_BIT = 12;
  localparam int DATA_LSB = 4;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    GAP,
    LDAC,
    DONE
  } state_t;

  function automatic logic [FRAME_W-1:0] build_word(input logic ch,
                                                    input logic shdn_n,
                                                    input logic [DATA_W-1:0] code);
    logic [FRAME_W-1:0] w;
    w                     = '0;
    w[CH_BIT]             = ch;
    w[GA_BIT]             = 1'b1;
    w[SHDN_BIT]           = shdn_n;
    w[DATA_LSB +: DATA_W] = code;
    return w;
  endfunction

endpackage

// File: rtl/dac_spi_serializer_if.sv
// Request side (codes, enable, valid) and SPI/status side of the serializer.
// master = the requesting stage, slave = the serializer itself.
interface dac_spi_serializer_if;
  import dandy_pkg::*;

  logic              sample_valid;
  logic [DATA_W-1:0] xdac;
  logic [DATA_W-1:0] ydac;
  logic              dac_en;
  logic              busy;
  logic              frame_done;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic              ldac_n;

  modport master (
    output sample_valid, xdac, ydac, dac_en,
    input  busy, frame_done, spi_sclk, spi_mosi, spi_cs_n, ldac_n
  );

  modport slave (
    input  sample_valid, xdac, ydac, dac_en,
    output busy, frame_done, spi_sclk, spi_mosi, spi_cs_n, ldac_n
  );

endinterface

// File: rtl/dac_spi_serializer_tick_gen.sv
// Free-running CLK_DIV divider; tick is high for one cycle every CLK_DIV cycles.
// clear restarts the count so the first tick lands exactly CLK_DIV cycles later.
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_spi_serializer.sv
// Latches X/Y codes on request and sends two SPI mode-0 frames then an LDAC strobe;
// request to frame_done is 69*CLK_DIV+1 cycles, requests are ignored while busy.
module dac_spi_serializer
  import dandy_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dac_spi_serializer_if.slave  bus
);

  state_t             state;
  logic               ch;
  logic [4:0]         hcnt;
  logic [FRAME_W-1:0] shreg;
  logic [DATA_W-1:0]  y_code;
  logic               en_q;
  logic               tick;
  logic               accept;
  logic [FRAME_W-1:0] word_a;
  logic [FRAME_W-1:0] word_b;

  logic sclk_q, mosi_q, cs_n_q, ldac_n_q, busy_q, done_q;

  assign accept = (state == IDLE) && bus.sample_valid;
  assign word_a = build_word(1'b0, bus.dac_en, bus.xdac);
  assign word_b = build_word(1'b1, en_q, y_code);

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .clear (~rst_n | accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch       <= 1'b0;
      hcnt     <= '0;
      shreg    <= '0;
      y_code   <= '0;
      en_q     <= 1'b0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ldac_n_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sample_valid) begin
            shreg  <= word_a;
            mosi_q <= word_a[FRAME_W-1];
            y_code <= bus.ydac;
            en_q   <= bus.dac_en;
            ch     <= 1'b0;
            cs_n_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (tick) begin
            sclk_q <= 1'b1;
            hcnt   <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Even half-bits are the high phase; the final low half is the CS hold.
          if (tick) begin
            hcnt <= hcnt + 5'd1;
            if (!hcnt[0]) begin
              sclk_q <= 1'b0;
              shreg  <= {shreg[FRAME_W-2:0], 1'b0};
              mosi_q <= shreg[FRAME_W-2];
            end else if (hcnt == 5'd31) begin
              cs_n_q <= 1'b1;
              mosi_q <= 1'b0;
              state  <= GAP;
            end else begin
              sclk_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (!ch) begin
              ch     <= 1'b1;
              shreg  <= word_b;
              mosi_q <= word_b[FRAME_W-1];
              cs_n_q <= 1'b0;
              state  <= CS_SETUP;
            end else begin
              ldac_n_q <= 1'b0;
              state    <= LDAC;
            end
          end
        end
        LDAC: begin
          if (tick) begin
            ldac_n_q <= 1'b1;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_sclk   = sclk_q;
  assign bus.spi_mosi   = mosi_q;
  assign bus.spi_cs_n   = cs_n_q;
  assign bus.ldac_n     = ldac_n_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Directed bench: two serializers (CLK_DIV=2 and CLK_DIV=1) observed by an SPI slave monitor.
module tb_dac_spi_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // sel=0 observes/drives the CLK_DIV=2 unit, sel=1 the CLK_DIV=1 unit
  logic       sel = 1'b0;
  logic       b_valid = 1'b0;
  logic [7:0] b_x = 8'h00;
  logic [7:0] b_y = 8'h00;
  logic       b_en = 1'b0;

  dac_spi_serializer_if if_a ();
  dac_spi_serializer_if if_b ();

  assign if_a.sample_valid = b_valid & ~sel;
  assign if_a.xdac = b_x;
  assign if_a.ydac = b_y;
  assign if_a.dac_en = b_en;
  assign if_b.sample_valid = b_valid & sel;
  assign if_b.xdac = b_x;
  assign if_b.ydac = b_y;
  assign if_b.dac_en = b_en;

  dac_spi_serializer #(.CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  dac_spi_serializer #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  logic m_sclk, m_mosi, m_cs, m_ldac, m_busy, m_done;
  assign m_sclk = sel ? if_b.spi_sclk   : if_a.spi_sclk;
  assign m_mosi = sel ? if_b.spi_mosi   : if_a.spi_mosi;
  assign m_cs   = sel ? if_b.spi_cs_n   : if_a.spi_cs_n;
  assign m_ldac = sel ? if_b.ldac_n     : if_a.ldac_n;
  assign m_busy = sel ? if_b.busy       : if_a.busy;
  assign m_done = sel ? if_b.frame_done : if_a.frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state
  int          clr_req = 0, clr_ack = 0;
  int          cyc = 0, nb = 0, rises = 0, viol = 0;
  int          ldac_cyc = 0, ldac_pulses = 0, done_cnt = 0;
  logic [15:0] sh = 16'h0;
  logic        p_sclk = 1'b0, p_cs = 1'b1, p_ldac = 1'b1;
  logic [15:0] words[$];
  int          bits[$];
  int          done_cyc[$];
  int          acc_cyc[$];
  logic [7:0]  acc_x[$];

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      words.delete(); bits.delete(); done_cyc.delete(); acc_cyc.delete(); acc_x.delete();
      nb = 0; rises = 0; viol = 0; ldac_cyc = 0; ldac_pulses = 0; done_cnt = 0; sh = 16'h0;
      clr_ack = clr_req;
    end
    cyc++;
    if (m_cs === 1'b0 && m_sclk === 1'b1 && p_sclk === 1'b0) begin
      sh = {sh[14:0], m_mosi};
      nb++;
      rises++;
    end
    if (m_cs === 1'b1 && p_cs === 1'b0) begin
      words.push_back(sh);
      bits.push_back(nb);
      nb = 0;
      sh = 16'h0;
    end
    if (m_cs === 1'b1 && m_sclk === 1'b1) viol++;
    if (m_ldac === 1'b0) ldac_cyc++;
    if (m_ldac === 1'b0 && p_ldac === 1'b1) ldac_pulses++;
    if (m_done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (b_valid && m_busy === 1'b0 && rst_n) begin
      acc_cyc.push_back(cyc);
      acc_x.push_back(b_x);
    end
    p_sclk = m_sclk;
    p_cs   = m_cs;
    p_ldac = m_ldac;
  end

  task automatic clr_mon();
    clr_req = clr_req + 1;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] x, input logic [7:0] y, input logic en);
    @(posedge clk); #1;
    b_x = x; b_y = y; b_en = en; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (if_a.spi_cs_n !== 1'b1)   begin n_bad++; $display("FAIL rst_cs_n_a got %b exp 1", if_a.spi_cs_n); end
    n_cmp++; if (if_a.spi_sclk !== 1'b0)   begin n_bad++; $display("FAIL rst_sclk_a got %b exp 0", if_a.spi_sclk); end
    n_cmp++; if (if_a.spi_mosi !== 1'b0)   begin n_bad++; $display("FAIL rst_mosi_a got %b exp 0", if_a.spi_mosi); end
    n_cmp++; if (if_a.ldac_n !== 1'b1)     begin n_bad++; $display("FAIL rst_ldac_a got %b exp 1", if_a.ldac_n); end
    n_cmp++; if (if_a.busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy_a got %b exp 0", if_a.busy); end
    n_cmp++; if (if_a.frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done_a got %b exp 0", if_a.frame_done); end
    n_cmp++; if (if_b.spi_cs_n !== 1'b1)   begin n_bad++; $display("FAIL rst_cs_n_b got %b exp 1", if_b.spi_cs_n); end
    n_cmp++; if (if_b.spi_sclk !== 1'b0)   begin n_bad++; $display("FAIL rst_sclk_b got %b exp 0", if_b.spi_sclk); end
    n_cmp++; if (if_b.ldac_n !== 1'b1)     begin n_bad++; $display("FAIL rst_ldac_b got %b exp 1", if_b.ldac_n); end
    n_cmp++; if (if_b.busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy_b got %b exp 0", if_b.busy); end
    rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic test_basic();
    bit ok;
    sel = 1'b0;
    clr_mon();
    request(8'hFA, 8'h0A, 1'b1);
    wait_done(1, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout got no frame_done exp frame_done"); end
    n_cmp++; if (words.size() !== 2) begin n_bad++; $display("FAIL basic_nwords got %0d exp 2", words.size()); end
    n_cmp++; if (words[0] !== 16'h3FA0) begin n_bad++; $display("FAIL basic_word_a got %h exp 3fa0", words[0]); end
    n_cmp++; if (words[1] !== 16'hB0A0) begin n_bad++; $display("FAIL basic_word_b got %h exp b0a0", words[1]); end
    n_cmp++; if (bits[0] !== 16 || bits[1] !== 16) begin n_bad++; $display("FAIL basic_sclk_rises got %0d/%0d exp 16/16", bits[0], bits[1]); end
    n_cmp++; if (ldac_cyc !== 2) begin n_bad++; $display("FAIL basic_ldac_len got %0d exp 2", ldac_cyc); end
    n_cmp++; if (ldac_pulses !== 1) begin n_bad++; $display("FAIL basic_ldac_pulses got %0d exp 1", ldac_pulses); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    n_cmp++; if (done_cyc[0] - acc_cyc[0] !== 139) begin n_bad++; $display("FAIL basic_latency got %0d exp 139", done_cyc[0] - acc_cyc[0]); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL basic_sclk_high_cs_off got %0d exp 0", viol); end
  endtask

  task automatic test_shutdown();
    bit ok;
    sel = 1'b0;
    clr_mon();
    request(8'h55, 8'hC3, 1'b0);
    wait_done(1, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL shdn_timeout got no frame_done exp frame_done"); end
    n_cmp++; if (words[0] !== 16'h2550) begin n_bad++; $display("FAIL shdn_word_a got %h exp 2550", words[0]); end
    n_cmp++; if (words[1] !== 16'hAC30) begin n_bad++; $display("FAIL shdn_word_b got %h exp ac30", words[1]); end
    n_cmp++; if (words[0][12] !== 1'b0 || words[1][12] !== 1'b0) begin n_bad++; $display("FAIL shdn_bit12 got %b%b exp 00", words[0][12], words[1][12]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] exp_w;
    sel = 1'b0;
    clr_mon();
    b_x = 8'h10; b_y = 8'h5A; b_en = 1'b1; b_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= 3) begin
        b_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      b_x = b_x + 8'd7;
    end
    b_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout got %0d frames exp 3", done_cnt); end
    n_cmp++; if (acc_cyc.size() !== 3) begin n_bad++; $display("FAIL b2b_accepts got %0d exp 3", acc_cyc.size()); end
    n_cmp++; if (words.size() !== 6) begin n_bad++; $display("FAIL b2b_nwords got %0d exp 6", words.size()); end
    for (int k = 0; k < 3; k++) begin
      exp_w = {4'h3, acc_x[k], 4'h0};
      n_cmp++; if (words[2*k] !== exp_w) begin n_bad++; $display("FAIL b2b_word_a%0d got %h exp %h", k, words[2*k], exp_w); end
      n_cmp++; if (words[2*k+1] !== 16'hB5A0) begin n_bad++; $display("FAIL b2b_word_b%0d got %h exp b5a0", k, words[2*k+1]); end
    end
    n_cmp++; if (acc_x[0] === acc_x[1]) begin n_bad++; $display("FAIL b2b_x_changed got %h twice exp distinct", acc_x[0]); end
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (acc_cyc[k+1] !== done_cyc[k] + 1) begin n_bad++; $display("FAIL b2b_gap%0d got %0d exp %0d", k, acc_cyc[k+1], done_cyc[k] + 1); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    sel = 1'b0;
    clr_mon();
    request(8'h81, 8'h42, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rises >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_wait got %0d rises exp 5", rises); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (if_a.spi_cs_n !== 1'b1) begin n_bad++; $display("FAIL abort_cs_n got %b exp 1", if_a.spi_cs_n); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b exp 0", if_a.busy); end
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    n_cmp++; if (ldac_pulses !== 0) begin n_bad++; $display("FAIL abort_ldac got %0d exp 0", ldac_pulses); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
    clr_mon();
    request(8'h81, 8'h42, 1'b1);
    wait_done(1, 400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL abort_retry_timeout got no frame_done exp frame_done"); end
    n_cmp++; if (words[0] !== 16'h3810) begin n_bad++; $display("FAIL abort_retry_a got %h exp 3810", words[0]); end
    n_cmp++; if (words[1] !== 16'hB420) begin n_bad++; $display("FAIL abort_retry_b got %h exp b420", words[1]); end
    n_cmp++; if (ldac_pulses !== 1) begin n_bad++; $display("FAIL abort_retry_ldac got %0d exp 1", ldac_pulses); end
  endtask

  task automatic test_div1();
    bit ok;
    sel = 1'b1;
    clr_mon();
    request(8'h00, 8'hFF, 1'b1);
    wait_done(1, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL div1_timeout got no frame_done exp frame_done"); end
    n_cmp++; if (words[0] !== 16'h3000) begin n_bad++; $display("FAIL div1_word_a got %h exp 3000", words[0]); end
    n_cmp++; if (words[1] !== 16'hBFF0) begin n_bad++; $display("FAIL div1_word_b got %h exp bff0", words[1]); end
    n_cmp++; if (done_cyc[0] - acc_cyc[0] !== 70) begin n_bad++; $display("FAIL div1_latency got %0d exp 70", done_cyc[0] - acc_cyc[0]); end
    n_cmp++; if (ldac_cyc !== 1) begin n_bad++; $display("FAIL div1_ldac_len got %0d exp 1", ldac_cyc); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL div1_sclk_high_cs_off got %0d exp 0", viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shutdown();
    test_back_to_back();
    test_abort();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
